// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4-Lite SRAM slave.
// Holds the AXI response codes, the read/write FSM state types and the
// address-decode helpers used by the slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_RESP = 2'b10
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_WAIT = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    // True when byte address a falls inside [base, base + 4*2^aw).
    // DEPTH is a power of two, so "offset < span" reduces to checking that
    // no offset bit above the word-index field is set.
    function automatic logic addr_in_range(input logic [31:0] a,
                                           input logic [31:0] base,
                                           input int          aw);
        logic [31:0] off;
        off = a - base;
        return (a >= base) && ((off >> (aw + 2)) == 32'd0);
    endfunction

    // Word offset of byte address a relative to base; a[1:0] drops out.
    function automatic logic [31:0] word_offset(input logic [31:0] a,
                                                input logic [31:0] base);
        return (a - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word-organised storage for the AXI4-Lite SRAM slave.
// Ports:
//   clk_i            clock, rising edge
//   re_i / raddr_i   read enable and word index; rdata_o updates on the edge
//   rdata_o          registered read data, held while re_i is low
//   we_i / waddr_i   write enable and word index
//   wdata_i/wstrb_i  write data and byte-lane enables
// The array has no reset: contents survive a reset of the surrounding slave.
// A read and a write to the same word on one edge returns the old word.
module sram_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wstrb_i
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Registered read port and byte-masked write port.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave backed by an on-chip SRAM.
// Ports:
//   clk, rst (async, active-low)
//   AR channel: ARADDR, ARVALID, ARREADY     R channel: RDATA, RRESP, RVALID, RREADY
//   AW channel: AWADDR, AWVALID, AWREADY     W channel: WDATA, WSTRB, WVALID, WREADY
//   B channel : BRESP, BVALID, BREADY
// One outstanding read and one outstanding write, handled by independent
// FSMs. Addresses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) answer SLVERR,
// read back zero and never touch the array. All handshake outputs are
// registers loaded from the next-state decode.
module axi4_lite_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          DEPTH         = 1024,
    parameter int          READ_LATENCY  = 1,
    parameter int          WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY
);

    localparam int AW = $clog2(DEPTH);

    rd_state_e   rd_state_q, rd_state_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arready_q, rvalid_q, rd_hit_q;
    logic [1:0]  rresp_q;

    wr_state_e   wr_state_q, wr_state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;

    logic        ar_hs_s, aw_hs_s, w_hs_s;
    logic        rd_enter_s, wr_enter_s, rd_ok_s, wr_ok_s;
    logic [31:0] rd_addr_s, rd_off_s, wr_off_s, sram_rdata_s;

    assign ar_hs_s = ARVALID & arready_q;
    assign aw_hs_s = AWVALID & awready_q;
    assign w_hs_s  = WVALID & wready_q;

    // With zero latency the array is read on the handshake edge itself, so
    // the live ARADDR is used while idle.
    assign rd_addr_s  = (rd_state_q == R_IDLE) ? ARADDR : araddr_q;
    assign rd_ok_s    = addr_in_range(rd_addr_s, BASE_ADDR, AW);
    assign rd_off_s   = word_offset(rd_addr_s, BASE_ADDR);
    assign rd_enter_s = (rd_state_d == R_RESP) && (rd_state_q != R_RESP);

    // Read FSM next state.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        araddr_d   = araddr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    araddr_d   = ARADDR;
                    rd_cnt_d   = 4'(READ_LATENCY);
                    rd_state_d = (READ_LATENCY == 0) ? R_RESP : R_WAIT;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == 4'd1) begin
                    rd_cnt_d   = 4'd0;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d   = rd_cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_RESP;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rd_cnt_d   = 4'd0;
            end
        endcase
    end

    // Read FSM state, handshake outputs and response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= 4'd0;
            araddr_q   <= 32'd0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rd_hit_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            araddr_q   <= araddr_d;
            arready_q  <= (rd_state_d == R_IDLE);
            rvalid_q   <= (rd_state_d == R_RESP);
            if (rd_enter_s) begin
                rresp_q  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
                rd_hit_q <= rd_ok_s;
            end
        end
    end

    // Next-state values double as the commit address/data: on the edge a
    // zero-latency write completes they already carry the live bus values.
    assign wr_ok_s    = addr_in_range(awaddr_d, BASE_ADDR, AW);
    assign wr_off_s   = word_offset(awaddr_d, BASE_ADDR);
    assign wr_enter_s = (wr_state_d == W_RESP) && (wr_state_q != W_RESP);

    // Write FSM next state; AW and W are captured independently while idle.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        awaddr_d   = aw_hs_s ? AWADDR : awaddr_q;
        wdata_d    = w_hs_s ? WDATA : wdata_q;
        wstrb_d    = w_hs_s ? WSTRB : wstrb_q;
        aw_done_d  = aw_done_q | aw_hs_s;
        w_done_d   = w_done_q | w_hs_s;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_done_d && w_done_d) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_cnt_d   = 4'(WRITE_LATENCY);
                    wr_state_d = (WRITE_LATENCY == 0) ? W_RESP : W_WAIT;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == 4'd1) begin
                    wr_cnt_d   = 4'd0;
                    wr_state_d = W_RESP;
                end else begin
                    wr_cnt_d   = wr_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                wr_cnt_d   = 4'd0;
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
            end
        endcase
    end

    // Write FSM state, captured beats, handshake outputs and response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= 4'd0;
            awaddr_q   <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awready_q  <= (wr_state_d == W_IDLE) && !aw_done_d;
            wready_q   <= (wr_state_d == W_IDLE) && !w_done_d;
            bvalid_q   <= (wr_state_d == W_RESP);
            if (wr_enter_s) begin
                bresp_q <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    sram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk_i   (clk),
        .re_i    (rd_enter_s),
        .raddr_i (rd_off_s[AW-1:0]),
        .rdata_o (sram_rdata_s),
        .we_i    (wr_enter_s & wr_ok_s),
        .waddr_i (wr_off_s[AW-1:0]),
        .wdata_i (wdata_d),
        .wstrb_i (wstrb_d)
    );

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    // Array output is only exposed after an in-range read; otherwise zero.
    assign RDATA   = rd_hit_q ? sram_rdata_s : 32'd0;
    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Self-checking bench for axi4_lite_sram_slave (READ_LATENCY=2, WRITE_LATENCY=1).
module tb_axi4_lite_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [1:0]  RRESP, BRESP;
    logic [3:0]  WSTRB;

    int errors = 0;
    int checks = 0;

    axi4_lite_sram_slave #(
        .BASE_ADDR     (32'h8000_0000),
        .DEPTH         (1024),
        .READ_LATENCY  (2),
        .WRITE_LATENCY (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        do_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        int   n;
        logic aw_pend, w_pend, aw_f, w_f;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            tick();
            if (aw_f) begin AWVALID = 1'b0; aw_pend = 1'b0; end
            if (w_f)  begin WVALID = 1'b0;  w_pend = 1'b0;  end
            n++;
        end
        while (!BVALID && n < 40) begin
            tick();
            n++;
        end
        check("wr_bvalid_seen", {31'd0, BVALID}, 32'd1);
        resp = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        int   n;
        logic fire;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
        n = 0; fire = 1'b0;
        while (!fire && n < 20) begin
            fire = ARREADY;
            tick();
            n++;
        end
        ARVALID = 1'b0;
        lat = 1;
        while (!RVALID && lat < 30) begin
            tick();
            lat++;
        end
        check("rd_rvalid_seen", {31'd0, RVALID}, 32'd1);
        d = RDATA;
        resp = RRESP;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br;
        int          lat, bcnt;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00};
        vecs[1]  = '{1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF, 2'b00, 32'h8000_0004, 32'h1122_3344, 2'b00};
        vecs[2]  = '{1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h8000_0004, 32'h11BB_33DD, 2'b00};
        vecs[3]  = '{1'b1, 32'h8000_0004, 32'h0000_0000, 4'h2, 2'b00, 32'h8000_0004, 32'h11BB_00DD, 2'b00};
        vecs[4]  = '{1'b1, 32'h8000_0FFC, 32'h5A5A_A5A5, 4'hF, 2'b00, 32'h8000_0FFC, 32'h5A5A_A5A5, 2'b00};
        vecs[5]  = '{1'b1, 32'h8000_0003, 32'h0102_0304, 4'hF, 2'b00, 32'h8000_0002, 32'h0102_0304, 2'b00};
        vecs[6]  = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h8000_1000, 32'h0000_0000, 2'b10};
        vecs[7]  = '{1'b1, 32'h7FFF_FFFC, 32'hEEEE_EEEE, 4'hF, 2'b10, 32'h7FFF_FFFC, 32'h0000_0000, 2'b10};
        vecs[8]  = '{1'b0, 32'h0,         32'h0,         4'h0, 2'b00, 32'h8000_0000, 32'h0102_0304, 2'b00};
        vecs[9]  = '{1'b0, 32'h0,         32'h0,         4'h0, 2'b00, 32'h8000_0FFC, 32'h5A5A_A5A5, 2'b00};
        vecs[10] = '{1'b0, 32'h0,         32'h0,         4'h0, 2'b00, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00};

        rst = 1'b0;
        ARADDR = 32'd0; ARVALID = 1'b0; RREADY = 1'b0;
        AWADDR = 32'd0; AWVALID = 1'b0; WDATA = 32'd0; WSTRB = 4'd0; WVALID = 1'b0; BREADY = 1'b0;
        tick();
        tick();
        check("rst_arready", {31'd0, ARREADY}, 32'd0);
        check("rst_awready", {31'd0, AWREADY}, 32'd0);
        check("rst_wready",  {31'd0, WREADY},  32'd0);
        check("rst_rvalid",  {31'd0, RVALID},  32'd0);
        check("rst_bvalid",  {31'd0, BVALID},  32'd0);
        check("rst_rdata",   RDATA,            32'd0);
        check("rst_rresp",   {30'd0, RRESP},   32'd0);
        check("rst_bresp",   {30'd0, BRESP},   32'd0);
        rst = 1'b1;
        #1;
        check("rel_arready_before_edge", {31'd0, ARREADY}, 32'd0);
        tick();
        check("rel_arready", {31'd0, ARREADY}, 32'd1);
        check("rel_awready", {31'd0, AWREADY}, 32'd1);
        check("rel_wready",  {31'd0, WREADY},  32'd1);

        // Table-driven write/readback vectors.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_wr) begin
                do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, br);
                check($sformatf("v%0d_bresp", i), {30'd0, br}, {30'd0, vecs[i].bresp});
            end
            do_read(vecs[i].raddr, rd, rr, lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_rresp", i), {30'd0, rr}, {30'd0, vecs[i].rresp});
            check($sformatf("v%0d_rlat", i), 32'(lat), 32'd3);
        end

        // Backpressure: RREADY low for 5 cycles with RVALID up.
        do_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF, br);
        ARADDR = 32'h8000_0020; ARVALID = 1'b1; RREADY = 1'b0;
        check("bp_arready_pre", {31'd0, ARREADY}, 32'd1);
        tick();
        ARVALID = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_rvalid_%0d", k), {31'd0, RVALID}, 32'd1);
            check($sformatf("bp_rdata_%0d", k), RDATA, 32'hCAFE_F00D);
            check($sformatf("bp_arready_%0d", k), {31'd0, ARREADY}, 32'd0);
            tick();
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check("bp_rvalid_after", {31'd0, RVALID}, 32'd0);
        check("bp_arready_after", {31'd0, ARREADY}, 32'd1);

        // AW/W skew: W three cycles ahead of AW.
        WDATA = 32'h1234_5678; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0; WDATA = 32'hFFFF_FFFF;
        check("skew_wready_drop", {31'd0, WREADY}, 32'd0);
        check("skew_awready_up", {31'd0, AWREADY}, 32'd1);
        tick();
        tick();
        check("skew_no_early_b", {31'd0, BVALID}, 32'd0);
        AWADDR = 32'h8000_0030; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (BVALID) bcnt++;
            tick();
        end
        BREADY = 1'b0;
        check("skew_b_pulses", 32'(bcnt), 32'd1);
        do_read(32'h8000_0030, rd, rr, lat);
        check("skew_rdata", rd, 32'h1234_5678);

        // Reset while the read sits in its latency wait.
        ARADDR = 32'h8000_0010; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        rst = 1'b0;
        #1;
        check("mrst_rvalid", {31'd0, RVALID}, 32'd0);
        check("mrst_arready", {31'd0, ARREADY}, 32'd0);
        check("mrst_awready", {31'd0, AWREADY}, 32'd0);
        check("mrst_wready", {31'd0, WREADY}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("mrst_arready_rel", {31'd0, ARREADY}, 32'd1);
        check("mrst_wready_rel", {31'd0, WREADY}, 32'd1);
        check("mrst_rvalid_rel", {31'd0, RVALID}, 32'd0);
        do_read(32'h8000_0010, rd, rr, lat);
        check("mrst_mem_intact", rd, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
